// File: rtl/psram_ctrl_pkg.sv
// Shared definitions for the PSRAM controller: FSM state encodings,
// the registered control-vector constants and small helpers.
package psram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_TURN  = 3'd4
  } state_e;

  // Control vector bit order: {Adv, Clk, CS, OE, WR, LB, UB}
  localparam logic [6:0] CTRL_IDLE  = 7'b1111111;
  localparam logic [6:0] CTRL_READ  = 7'b0000100;
  // Write and hold leave LB/UB at zero here; byte lanes are OR-ed in.
  localparam logic [6:0] CTRL_WRITE = 7'b0001000;
  localparam logic [6:0] CTRL_HOLD  = 7'b0001100;

  // Apply active-low byte-lane strobes derived from the byte enables.
  function automatic logic [6:0] ctrl_lanes(input logic [6:0] base, input logic [1:0] be);
    return base | {5'b00000, ~be[0], ~be[1]};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/psram_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// The count stops at zero rather than wrapping.
module psram_timer #(
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  // Load on state entry, otherwise count down and park at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/psram_ctrl.sv
// Asynchronous-mode cellular RAM controller. Accepts single-word read or
// byte-enabled write requests over valid/ready and sequences the RAM pins
// with parameterised wait, hold and turnaround timing. All RAM pins are
// driven from registers; the data bus enable is a registered drive flag.
module psram_ctrl
  import psram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int RD_WAIT     = 6,
  parameter int WR_WAIT     = 6,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [1:0]        req_be,
  output logic              rd_valid,
  output logic [15:0]       rd_data,
  output logic              wr_done,
  output logic [ADDR_W-1:0] MemAdr,
  inout  wire  [15:0]       MemDB,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB
);

  localparam int            MAX_WAIT = max3(RD_WAIT, WR_WAIT, TURN_CYCLES);
  localparam int            CW       = $clog2(MAX_WAIT + 1);
  localparam bit            HAS_TURN = (TURN_CYCLES > 0);
  // Timer is loaded with N-1 so the state exits on the Nth edge after entry.
  localparam logic [CW-1:0] RD_LD    = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LD    = CW'(WR_WAIT - 1);
  localparam logic [CW-1:0] TURN_LD  = HAS_TURN ? CW'(TURN_CYCLES - 1) : '0;

  state_e              state_q, state_d;
  logic [6:0]          ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_done_q, wr_done_d;
  logic                ready_q, ready_d;
  logic                drv_q, drv_d;
  logic                null_q, null_d;
  logic                tmr_load;
  logic [CW-1:0]       tmr_val;
  logic                tmr_done;

  psram_timer #(.CW(CW)) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state, next control vector and strobes for the access sequencer.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    drv_d      = drv_q;
    null_d     = null_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          tmr_load = 1'b1;
          if (!req_we) begin
            state_d = S_READ;
            tmr_val = RD_LD;
            ctrl_d  = CTRL_READ;
          end else if (req_be == 2'b00) begin
            // Nothing to write: skip the bus cycle, just report completion.
            state_d = S_HOLD;
            null_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            null_d  = 1'b0;
            drv_d   = 1'b1;
            tmr_val = WR_LD;
            ctrl_d  = ctrl_lanes(CTRL_WRITE, req_be);
          end
        end
      end
      S_READ: begin
        if (tmr_done) begin
          rd_data_d  = MemDB;
          rd_valid_d = 1'b1;
          ctrl_d     = CTRL_IDLE;
          if (HAS_TURN) begin
            state_d  = S_TURN;
            tmr_load = 1'b1;
            tmr_val  = TURN_LD;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (tmr_done) begin
          // WR rises first; CS and byte lanes stay put while data is held.
          state_d  = S_HOLD;
          tmr_load = 1'b1;
          ctrl_d   = CTRL_HOLD | {5'b00000, ctrl_q[1:0]};
        end
      end
      S_HOLD: begin
        if (tmr_done) begin
          drv_d     = 1'b0;
          wr_done_d = 1'b1;
          ctrl_d    = CTRL_IDLE;
          if (HAS_TURN && !null_q) begin
            state_d  = S_TURN;
            tmr_load = 1'b1;
            tmr_val  = TURN_LD;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      S_TURN: begin
        if (tmr_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ctrl_d  = CTRL_IDLE;
        drv_d   = 1'b0;
      end
    endcase
  end

  assign ready_d = (state_d == S_IDLE);

  // State, pin and data registers; reset forces the bus idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ctrl_q     <= CTRL_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      ready_q    <= 1'b0;
      drv_q      <= 1'b0;
      null_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      ready_q    <= ready_d;
      drv_q      <= drv_d;
      null_q     <= null_d;
    end
  end

  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl_q;
  assign MemAdr    = addr_q;
  assign MemDB     = drv_q ? wdata_q : 16'hzzzz;
  assign req_ready = ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_psram_ctrl.sv
// Scoreboard bench for psram_ctrl: a default-parameter instance with a
// small byte-lane RAM model, plus a reduced-timing instance.
module tb_psram_ctrl;

  localparam int AW = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (ADDR_W=23, RD_WAIT=6, WR_WAIT=6, TURN_CYCLES=1)
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic [1:0]    req_be;
  logic          rd_valid, wr_done;
  logic [15:0]   rd_data;
  logic [AW-1:0] MemAdr;
  wire  [15:0]   MemDB;
  logic          RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB;
  wire  [6:0]    ctrl_v = {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB};

  psram_ctrl #(.ADDR_W(AW), .RD_WAIT(6), .WR_WAIT(6), .TURN_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_done(wr_done),
    .MemAdr(MemAdr), .MemDB(MemDB),
    .RamAdv(RamAdv), .RamClk(RamClk), .RamCS(RamCS), .MemOE(MemOE),
    .MemWR(MemWR), .RamLB(RamLB), .RamUB(RamUB)
  );

  // Reduced instance (ADDR_W=20, RD_WAIT=2, WR_WAIT=3, TURN_CYCLES=0)
  logic        s_valid, s_ready, s_we;
  logic [19:0] s_addr;
  logic [15:0] s_wdata;
  logic [1:0]  s_be;
  logic        s_rd_valid, s_wr_done;
  logic [15:0] s_rd_data;
  logic [19:0] s_MemAdr;
  wire  [15:0] s_MemDB;
  logic        s_Adv, s_Clk, s_CS, s_OE, s_WR, s_LB, s_UB;

  psram_ctrl #(.ADDR_W(20), .RD_WAIT(2), .WR_WAIT(3), .TURN_CYCLES(0)) u_small (
    .clk(clk), .rst(rst), .req_valid(s_valid), .req_ready(s_ready),
    .req_we(s_we), .req_addr(s_addr), .req_wdata(s_wdata), .req_be(s_be),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .wr_done(s_wr_done),
    .MemAdr(s_MemAdr), .MemDB(s_MemDB),
    .RamAdv(s_Adv), .RamClk(s_Clk), .RamCS(s_CS), .MemOE(s_OE),
    .MemWR(s_WR), .RamLB(s_LB), .RamUB(s_UB)
  );

  assign s_MemDB = (!s_OE && !s_CS) ? 16'h3C5A : 16'hzzzz;

  // RAM model: four word slots keyed by the addresses this bench uses
  logic [15:0] mem [4];
  logic [15:0] ram_q;

  function automatic int slot(input logic [AW-1:0] a);
    case (a)
      23'h000123: return 0;
      23'h7FFFFF: return 1;
      23'h000055: return 2;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic lb, input logic ub);
    return {ub ? old[15:8] : nw[15:8], lb ? old[7:0] : nw[7:0]};
  endfunction

  assign ram_q = mem[slot(MemAdr)];
  assign MemDB = (!MemOE && !RamCS) ? ram_q : 16'hzzzz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Scoreboard queues
  typedef struct { bit is_rd; logic [15:0] data; int due; } rsp_t;
  typedef struct { int len; logic [1:0] lbub; logic [15:0] data; } wexp_t;
  rsp_t  rsp_q[$];
  wexp_t exp_wr[$];
  int    exp_cs[$];

  // Response monitor: every rd_valid / wr_done pulse must match the head
  always @(negedge clk) begin
    if (rd_valid || wr_done) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'({rd_valid, wr_done}), 32'd0);
      end else begin
        chk("rsp_kind", 32'({rd_valid, wr_done}), rsp_q[0].is_rd ? 32'd2 : 32'd1);
        if (rsp_q[0].is_rd) chk("rd_data", 32'(rd_data), 32'(rsp_q[0].data));
        chk("rsp_cycle", cyc, rsp_q[0].due);
        void'(rsp_q.pop_front());
      end
    end
  end

  // Bus monitor: CS/WR pulse widths, byte lanes, held data, RAM writes
  logic        wr_prev = 1'b1;
  int          cs_run = 0;
  int          wr_run = 0;
  int          proto_bad = 0;
  logic [1:0]  lbub_seen = 2'b11;
  logic [15:0] db_seen = 16'h0;

  always @(negedge clk) begin
    wr_prev <= MemWR;
    if (!MemOE && (!MemWR || (MemDB !== ram_q))) proto_bad <= proto_bad + 1;
    if (!RamCS) begin
      cs_run <= cs_run + 1;
    end else if (cs_run != 0) begin
      if (exp_cs.size() == 0) chk("cs_unexpected", 32'(cs_run), 32'd0);
      else begin
        chk("cs_len", 32'(cs_run), 32'(exp_cs[0]));
        void'(exp_cs.pop_front());
      end
      cs_run <= 0;
    end
    if (!MemWR) begin
      wr_run <= wr_run + 1;
      if (wr_prev) begin
        lbub_seen <= {RamLB, RamUB};
        db_seen   <= MemDB;
      end
    end else if (!wr_prev) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", 32'(wr_run), 32'd0);
      else begin
        chk("wr_len", 32'(wr_run), 32'(exp_wr[0].len));
        chk("wr_lanes", 32'(lbub_seen), 32'(exp_wr[0].lbub));
        chk("wr_data", 32'(db_seen), 32'(exp_wr[0].data));
        chk("wr_hold_data", 32'(MemDB), 32'(exp_wr[0].data));
        void'(exp_wr.pop_front());
      end
      if (!RamCS) mem[slot(MemAdr)] <= merge(mem[slot(MemAdr)], MemDB, RamLB, RamUB);
      wr_run <= 0;
    end
  end

  // Present a request and return the accept edge number; leaves valid high
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [15:0] d,
                       input logic [1:0] be, output int acc);
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    acc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_s(input bit rd, output int at);
    at = -1000;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rd ? s_rd_valid : s_wr_done) begin
        at = cyc;
        return;
      end
    end
    chk(rd ? "s_rd_timeout" : "s_wr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, a2, t0, t1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    s_valid = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;
    mem[0] = 16'hBEEF; mem[1] = 16'h1234; mem[2] = 16'h0000; mem[3] = 16'h0000;
    #1 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'(ctrl_v), 32'h7F);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    chk("rst_adr", 32'(MemAdr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Read 0x000123 -> 0xBEEF, CS/OE low 6 cycles, ready again after edge 7
    issue(1'b0, 23'h000123, 16'h0, 2'b11, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b1, data: 16'hBEEF, due: a + 6});
    exp_cs.push_back(6);
    wait_cyc(a + 6);
    chk("rd_ready_e6", 32'(req_ready), 32'd0);
    wait_cyc(a + 7);
    chk("rd_ready_e7", 32'(req_ready), 32'd1);
    chk("adr_held", 32'(MemAdr), 32'h000123);

    // Write 0x7FFFFF data 0xA55A, low byte only
    issue(1'b1, 23'h7FFFFF, 16'hA55A, 2'b01, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b0, data: 16'h0, due: a + 7});
    exp_cs.push_back(7);
    exp_wr.push_back('{len: 6, lbub: 2'b01, data: 16'hA55A});
    wait_cyc(a + 8);
    chk("model_byte_lane", 32'(mem[1]), 32'h125A);
    chk("rd_data_held", 32'(rd_data), 32'hBEEF);
    chk("wr_ready_e8", 32'(req_ready), 32'd1);

    issue(1'b0, 23'h7FFFFF, 16'h0, 2'b11, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b1, data: 16'h125A, due: a + 6});
    exp_cs.push_back(6);

    // Back-to-back write then read, valid held high throughout
    issue(1'b1, 23'h000055, 16'hC3C3, 2'b11, a);
    rsp_q.push_back('{is_rd: 1'b0, data: 16'h0, due: a + 7});
    exp_cs.push_back(7);
    exp_wr.push_back('{len: 6, lbub: 2'b00, data: 16'hC3C3});
    issue(1'b0, 23'h000055, 16'h0, 2'b11, a2);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b1, data: 16'hC3C3, due: a2 + 6});
    exp_cs.push_back(6);
    chk("b2b_gap", a2 - a, 32'd9);

    // High byte only write, then read back
    issue(1'b1, 23'h000123, 16'h7700, 2'b10, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b0, data: 16'h0, due: a + 7});
    exp_cs.push_back(7);
    exp_wr.push_back('{len: 6, lbub: 2'b10, data: 16'h7700});
    issue(1'b0, 23'h000123, 16'h0, 2'b11, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b1, data: 16'h77EF, due: a + 6});
    exp_cs.push_back(6);

    // Write with no byte enables: no bus cycle, done at edge 1
    issue(1'b1, 23'h0000AA, 16'hFFFF, 2'b00, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b0, data: 16'h0, due: a + 1});
    wait_cyc(a + 1);
    chk("null_ready_e1", 32'(req_ready), 32'd1);
    chk("null_adr", 32'(MemAdr), 32'h0000AA);
    issue(1'b0, 23'h000123, 16'h0, 2'b11, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b1, data: 16'h77EF, due: a + 6});
    exp_cs.push_back(6);

    // Reset in the middle of a read
    issue(1'b0, 23'h000055, 16'h0, 2'b11, a);
    req_valid = 1'b0;
    exp_cs.push_back(4);
    wait_cyc(a + 3);
    #2 rst = 1'b0;
    #1;
    chk("abort_ctrl", 32'(ctrl_v), 32'h7F);
    chk("abort_ready", 32'(req_ready), 32'd0);
    chk("abort_adr", 32'(MemAdr), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    issue(1'b0, 23'h000055, 16'h0, 2'b11, a);
    req_valid = 1'b0;
    rsp_q.push_back('{is_rd: 1'b1, data: 16'hC3C3, due: a + 6});
    exp_cs.push_back(6);
    wait_cyc(a + 10);

    // Reduced-timing instance: read every 3 edges, write every 5 edges
    s_we = 1'b0; s_addr = 20'hFFFFF; s_wdata = 16'h0F0F; s_be = 2'b11; s_valid = 1'b1;
    wait_s(1'b1, t0);
    wait_s(1'b1, t1);
    chk("s_rd_gap", t1 - t0, 32'd3);
    chk("s_rd_data", 32'(s_rd_data), 32'h3C5A);
    chk("s_adr", 32'(s_MemAdr), 32'hFFFFF);
    s_we = 1'b1;
    wait_s(1'b0, t0);
    wait_s(1'b0, t1);
    chk("s_wr_gap", t1 - t0, 32'd5);
    s_valid = 1'b0;

    repeat (12) @(negedge clk);
    chk("rsp_drain", 32'(rsp_q.size()), 32'd0);
    chk("cs_drain", 32'(exp_cs.size()), 32'd0);
    chk("wr_drain", 32'(exp_wr.size()), 32'd0);
    chk("bus_protocol", 32'(proto_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
